// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: prescaled LED pattern controller (blink / chase / binary count).
// A shared prescaler divides clk into a step tick; each tick advances the LED pattern.
// Runs last a programmed number of steps, or continue until stopped when steps is 0.
// Optional feature macro: LED_BLINK_SEQ_PAUSE_EN adds a 'pause' input that freezes a run.
module led_blink_sequencer #(
    parameter int PRESCALE = 1_000_000,
    parameter int N_LEDS   = 4,
    parameter int STEP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] steps,
`ifdef LED_BLINK_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic [N_LEDS-1:0] led,
    output logic              busy,
    output logic              done,
    output logic              tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [PW-1:0]       presc_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [STEP_W-1:0]   steps_reg;
    logic [1:0]          mode_reg;
    logic [N_LEDS-1:0]   led_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                hold;
    logic                tick_int;
    logic [STEP_W-1:0]   step_inc;
    logic [N_LEDS-1:0]   led_rot;
    logic [N_LEDS-1:0]   led_next;
    logic [N_LEDS-1:0]   led_init;

`ifdef LED_BLINK_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Step strobe decoded from registered state; a paused run never ticks.
    assign tick_int = (state_reg == RUN) && (presc_reg == PRESC_MAX) && !hold;
    assign step_inc = step_reg + STEP_W'(1);

    // Chase pattern: rotate left by one, MSB wraps into LSB.
    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_rot
            assign led_rot[gi] = led_reg[(gi + N_LEDS - 1) % N_LEDS];
        end
    endgenerate

    // Pattern advance for the latched mode; mode 3 behaves like blink.
    always_comb begin
        led_next = ~led_reg;
        case (mode_reg)
            2'd1:    led_next = led_rot;
            2'd2:    led_next = led_reg + N_LEDS'(1);
            default: led_next = ~led_reg;
        endcase
    end

    // Pattern loaded when a run starts, chosen by the live mode input.
    always_comb begin
        led_init = '0;
        if (mode == 2'd1) begin
            led_init = N_LEDS'(1);
        end
    end

    // Sequencer FSM with prescaler, step counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            step_reg  <= '0;
            steps_reg <= '0;
            mode_reg  <= '0;
            led_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start && !stop) begin
                        state_reg <= RUN;
                        mode_reg  <= mode;
                        steps_reg <= steps;
                        presc_reg <= '0;
                        step_reg  <= '0;
                        led_reg   <= led_init;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over a coincident tick; no done pulse.
                        state_reg <= IDLE;
                        led_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (!hold) begin
                        if (presc_reg == PRESC_MAX) begin
                            presc_reg <= '0;
                            step_reg  <= step_inc;
                            led_reg   <= led_next;
                            if ((steps_reg != '0) && (step_inc == steps_reg)) begin
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            presc_reg <= presc_reg + PW'(1);
                        end
                    end
                end
                DONE: begin
                    // One-cycle completion pulse; LEDs keep the final pattern.
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign tick = tick_int;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Testbench for led_blink_sequencer (PRESCALE=4, N_LEDS=4, STEP_W=8).
// Expected outputs come from an arithmetic model: cycles since start divided by
// PRESCALE gives the number of updates, and each mode's pattern is a closed form of that.
// Define LED_BLINK_SEQ_PAUSE_EN to also exercise the pause input.
module tb_led_blink_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] steps = 8'd0;
`ifdef LED_BLINK_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic       tick;

    int n_checks = 0;
    int n_pass = 0;
    logic [3:0] model_led = 4'h0;

    led_blink_sequencer #(.PRESCALE(P), .N_LEDS(4), .STEP_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .steps (steps),
`ifdef LED_BLINK_SEQ_PAUSE_EN
        .pause (pause),
`endif
        .led   (led),
        .busy  (busy),
        .done  (done),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pattern after u updates, straight from the mode definitions.
    function automatic logic [3:0] pat(input logic [1:0] m, input int u);
        case (m)
            2'd1:    return 4'(1 << (u % 4));
            2'd2:    return 4'(u % 16);
            default: return (u % 2 == 1) ? 4'hF : 4'h0;
        endcase
    endfunction

    // Expected outputs t edges after the accepted start (t=0 is just after the start edge).
    function automatic void model(input logic [1:0] m, input int s, input int t,
                                  output logic [3:0] l, output logic b,
                                  output logic d, output logic k);
        if (s != 0 && t > s * P) begin
            l = pat(m, s); b = 1'b0; d = 1'b0; k = 1'b0;
        end else if (s != 0 && t == s * P) begin
            l = pat(m, s); b = 1'b0; d = 1'b1; k = 1'b0;
        end else begin
            l = pat(m, t / P); b = 1'b1; d = 1'b0; k = (t % P == P - 1);
        end
    endfunction

    // Start a run and check every cycle; noisy runs toggle start/mode/steps, which must be ignored.
    task automatic run_and_check(input logic [1:0] m, input int s, input int n,
                                 input bit noisy, input bit end_start);
        logic [3:0] el;
        logic eb, ed, ek;
        mode = m; steps = 8'(s); start = 1'b1; stop = 1'b0;
        for (int t = 0; t < n; t++) begin
            step();
            model(m, s, t, el, eb, ed, ek);
            n_checks += 4;
            if (led !== el) $display("FAIL run_led m=%0d s=%0d t=%0d: got %b expected %b", m, s, t, led, el);
            else n_pass++;
            if (busy !== eb) $display("FAIL run_busy m=%0d s=%0d t=%0d: got %b expected %b", m, s, t, busy, eb);
            else n_pass++;
            if (done !== ed) $display("FAIL run_done m=%0d s=%0d t=%0d: got %b expected %b", m, s, t, done, ed);
            else n_pass++;
            if (tick !== ek) $display("FAIL run_tick m=%0d s=%0d t=%0d: got %b expected %b", m, s, t, tick, ek);
            else n_pass++;
            if (t == n - 1) start = end_start;
            else if (noisy && (s == 0 || t <= s * P)) start = 1'($urandom % 2);
            else start = 1'b0;
            if (noisy) begin
                mode = 2'($urandom % 4);
                steps = 8'($urandom % 256);
            end
            model_led = el;
        end
        $display("run mode=%0d steps=%0d cycles=%0d led=%b", m, s, n, led);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_checks += 4;
        if (led !== 4'h0) $display("FAIL reset_led: got %b expected 0000", led); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        if (tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick); else n_pass++;
        rst = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_directed_chase();
        run_and_check(2'd1, 3, 3 * P + 2, 1'b0, 1'b0);
        n_checks++;
        if (led !== 4'b1000) $display("FAIL chase_final: got %b expected 1000", led); else n_pass++;
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            run_and_check(2'($urandom % 4), 1 + int'($urandom % 6), 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random_noisy();
        for (int r = 0; r < 8; r++) begin
            int s;
            s = 1 + int'($urandom % 6);
            run_and_check(2'($urandom % 4), s, s * P + 2, 1'b1, 1'b0);
        end
    endtask

    task automatic test_free_run_stop();
        // 260 ticks: past the 8-bit step counter wrap, 260 mod 16 = 4.
        run_and_check(2'd2, 0, 260 * P + 1, 1'b1, 1'b0);
        n_checks++;
        if (led !== 4'b0100) $display("FAIL free_run_led: got %b expected 0100", led); else n_pass++;
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks += 4;
        if (led !== 4'h0) $display("FAIL stop_led: got %b expected 0000", led); else n_pass++;
        if (busy !== 1'b0) $display("FAIL stop_busy: got %b expected 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL stop_done: got %b expected 0", done); else n_pass++;
        if (tick !== 1'b0) $display("FAIL stop_tick: got %b expected 0", tick); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || led !== 4'h0)
                $display("FAIL after_stop cyc=%0d: got done=%b busy=%b led=%b expected 0 0 0000", i, done, busy, led);
            else n_pass++;
        end
        model_led = 4'h0;
        $display("stop checked");
    endtask

    task automatic test_start_stop_idle();
        run_and_check(2'd1, 2, 2 * P + 2, 1'b0, 1'b0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks += 2;
            if (busy !== 1'b0) $display("FAIL start_stop_busy cyc=%0d: got %b expected 0", i, busy); else n_pass++;
            if (led !== model_led) $display("FAIL start_stop_led cyc=%0d: got %b expected %b", i, led, model_led); else n_pass++;
            step();
        end
        $display("start+stop in idle checked");
    endtask

    task automatic test_back_to_back();
        run_and_check(2'd0, 2, 2 * P + 1, 1'b0, 1'b1);
        step();
        n_checks += 3;
        if (busy !== 1'b0) $display("FAIL b2b_busy: got %b expected 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL b2b_done: got %b expected 0", done); else n_pass++;
        if (led !== 4'h0) $display("FAIL b2b_led: got %b expected 0000", led); else n_pass++;
        run_and_check(2'd2, 5, 5 * P + 2, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        run_and_check(2'd1, 5, 7, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (led !== 4'h0) $display("FAIL async_rst_led: got %b expected 0000", led); else n_pass++;
        if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b expected 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL async_rst_done: got %b expected 0", done); else n_pass++;
        if (tick !== 1'b0) $display("FAIL async_rst_tick: got %b expected 0", tick); else n_pass++;
        step(); step();
        rst = 1'b0;
        run_and_check(2'd1, 3, 3 * P + 2, 1'b0, 1'b0);
    endtask

`ifdef LED_BLINK_SEQ_PAUSE_EN
    task automatic test_pause();
        logic [3:0] el;
        logic eb, ed, ek;
        logic pause_prev;
        int pz;
        pz = 0;
        mode = 2'd2; steps = 8'd3; start = 1'b1; stop = 1'b0; pause = 1'b0;
        for (int t = 0; t < 3 * P + 12; t++) begin
            if (pause) pz++;
            pause_prev = pause;
            step();
            start = 1'b0;
            model(2'd2, 3, t - pz, el, eb, ed, ek);
            ek = ek && !pause_prev;
            n_checks += 3;
            if (led !== el) $display("FAIL pause_led t=%0d: got %b expected %b", t, led, el); else n_pass++;
            if (tick !== ek) $display("FAIL pause_tick t=%0d: got %b expected %b", t, tick, ek); else n_pass++;
            if (done !== ed) $display("FAIL pause_done t=%0d: got %b expected %b", t, done, ed); else n_pass++;
            pause = (t >= P && t < P + 10);
        end
        pause = 1'b0;
        $display("pause run led=%b", led);
    endtask
`endif

    initial begin
        test_reset();
        test_directed_chase();
        test_random_noisy();
        test_free_run_stop();
        test_start_stop_idle();
        test_back_to_back();
        test_async_reset();
`ifdef LED_BLINK_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Programmable LED pattern controller built around a shared prescaler. It divides `clk` down to a step tick and drives an N-bit LED bank through one of three patterns: blink, chase or binary count. Runs last a programmed number of steps, or run until stopped. It sits between the board-level control inputs (buttons/switches) and the LED pins, replacing ad-hoc free-running blink counters.

## Interface
- `PRESCALE`, default 1_000_000: clk cycles per step tick; legal range ≥ 2.
- `N_LEDS`, default 4: LED bank width; legal range ≥ 2.
- `STEP_W`, default 8: width of the step-count field.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request, sampled on the rising edge of `clk`.
- `stop`  in  1  abort request, sampled on the rising edge of `clk`.
- `mode`  in  2  pattern select: 0 blink, 1 chase, 2 binary count, 3 treated as 0.
- `steps`  in  STEP_W  number of steps per run; 0 = run until `stop`.
- `led`  out  N_LEDS  LED drive.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a finite run completes.
- `tick`  out  1  one-cycle step strobe, exported for other blocks.

## Operation
- States: IDLE, RUN, DONE.
- **Reset** forces IDLE immediately. Reset values: `led`=0, `busy`=0, `done`=0, `tick`=0, prescaler=0, step counter=0.
- **IDLE**
  - `start`=1 and `stop`=0 → RUN.
  - On that edge: latch `mode`/`steps`, clear prescaler and step counter, and load the initial pattern.
  - Initial pattern: blink all 0; chase 0…01; count 0.
  - `start` and `stop` both high in IDLE → stay in IDLE; no change.
- **RUN**
  - Prescaler counts 0 … PRESCALE-1 and wraps to 0. Width is $clog2(PRESCALE).
  - `tick` = (state==RUN && prescaler==PRESCALE-1), decoded from registers.
  - On each edge where `tick`=1, the step counter increments and `led` updates:
    - blink: invert all bits.
    - chase: rotate left by 1, MSB wraps into LSB.
    - count: add 1 modulo 2^N_LEDS.
  - Latched `steps` ≠ 0 and the update just made is step number `steps` → DONE.
  - `stop`=1 → IDLE on the next edge. `led` is cleared to 0 and no `done` pulse is issued. `stop` takes priority over a coincident tick.
  - `start` in RUN is ignored. Changes to `mode`/`steps` in RUN are ignored.
  - `steps`=0: the step counter wraps silently; the run never ends by itself.
- **DONE**
  - Lasts exactly one cycle with `done`=1 and `busy`=0, then → IDLE.
  - `led` holds the final pattern through DONE and IDLE until the next start or a reset.
  - `start` during DONE is ignored.

## Timing
- `start` accepted at edge E0: `busy`=1 from E0.
- First `tick` is high during the cycle ending at edge E0+PRESCALE. The first `led` update is visible after that edge. Later updates follow every PRESCALE cycles.
- Finite run of S steps:
  - `done` is high in the cycle after edge E0+S·PRESCALE.
  - `busy` falls at that same edge.
  - Back in IDLE one edge later.
- `stop` asserted at edge Es: `busy`=0 and `led`=0 after Es.
- Async reset mid-run: all outputs go to their reset values without waiting for a clock edge. There is no pending `done`.

## Configuration
- `LED_BLINK_SEQ_PAUSE_EN` defined:
  - Adds input port `pause` (1 bit).
  - While `pause`=1 in RUN, the prescaler and step counter freeze, `tick` is forced to 0 and `led` holds. Counting resumes from the frozen value once `pause`=0.
  - `stop` still acts during pause.
- Not defined: the port is absent and RUN always counts.

## Test plan
- PRESCALE=4, N_LEDS=4. Reset, then `start` with mode=1, steps=3:
  - `led` goes 0001→0010→0100→1000, changing every 4 cycles.
  - Single `done` pulse one cycle after the third update; `led` holds 1000.
- mode=2, steps=0, run 20 ticks → `led` = 0100 (20 mod 16). Then `stop` → `led`=0, `busy`=0, no `done`.
- mode=0, steps=2:
  - `led` goes 0000→1111→0000.
  - `tick` is high exactly 2 cycles in total, each for one cycle.
- `start`+`stop` in the same IDLE cycle → remains IDLE. `start` pulses during RUN → no restart; the tick phase is unchanged.
- Assert `rst` mid-run at a non-edge time → `led`, `busy`, `done`, `tick` go to 0 immediately. A following `start` restarts with the full PRESCALE latency.
- With `LED_BLINK_SEQ_PAUSE_EN`: mode=2, pause for 10 cycles after the first tick → second update is delayed by exactly 10 cycles and the count sequence is unbroken.
